// File: rtl/vadd_a_b_control_s_axi.sv
// rtl/vadd_a_b_control_s_axi.sv - AXI4-Lite ap_ctrl_hs register file for the Vadd A/B kernel
// Holds start/status/interrupt control and the scalar00, A and B kernel arguments.
module vadd_a_b_control_s_axi #(
   parameter int C_S_AXI_ADDR_WIDTH = 12,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                            ap_clk,
   input  logic                            areset,
   input  logic                            s_axi_control_awvalid,
   output logic                            s_axi_control_awready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
   input  logic                            s_axi_control_wvalid,
   output logic                            s_axi_control_wready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
   output logic                            s_axi_control_bvalid,
   input  logic                            s_axi_control_bready,
   output logic [1:0]                      s_axi_control_bresp,
   input  logic                            s_axi_control_arvalid,
   output logic                            s_axi_control_arready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
   output logic                            s_axi_control_rvalid,
   input  logic                            s_axi_control_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
   output logic [1:0]                      s_axi_control_rresp,
   output logic                            interrupt,
   output logic                            ap_start,
   input  logic                            ap_done,
   input  logic                            ap_idle,
   input  logic                            ap_ready,
   output logic [31:0]                     scalar00,
   output logic [63:0]                     A,
   output logic [63:0]                     B
);

   localparam logic [5:0] ADDR_CTRL   = 6'h00;
   localparam logic [5:0] ADDR_GIE    = 6'h04;
   localparam logic [5:0] ADDR_IER    = 6'h08;
   localparam logic [5:0] ADDR_ISR    = 6'h0C;
   localparam logic [5:0] ADDR_SCALAR = 6'h10;
   localparam logic [5:0] ADDR_A_LO   = 6'h18;
   localparam logic [5:0] ADDR_A_HI   = 6'h1C;
   localparam logic [5:0] ADDR_B_LO   = 6'h24;
   localparam logic [5:0] ADDR_B_HI   = 6'h28;

   typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wstate_t;
   typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rstate_t;

   wstate_t     wstate_q;
   rstate_t     rstate_q;
   logic [5:0]  waddr_q;
   logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [31:0] rdata_q;

   logic        ap_start_q, ap_start_d;
   logic        auto_restart_q, auto_restart_d;
   logic        done_q, done_d;
   logic        ap_idle_r_q, ap_idle_r_d;
   logic        ap_ready_r_q, ap_ready_r_d;
   logic        gie_q, gie_d;
   logic [1:0]  ier_q, ier_d;
   logic [1:0]  isr_q, isr_d;
   logic        interrupt_q, interrupt_d;
   logic [31:0] scalar00_q, scalar00_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;

   logic        w_hs, ar_hs;
   logic [5:0]  raddr;
   logic [31:0] wmask, rdata_mux;
   logic        unused_addr_bits;

   assign w_hs  = s_axi_control_wvalid & wready_q;
   assign ar_hs = s_axi_control_arvalid & arready_q;
   assign raddr = s_axi_control_araddr[5:0];
   assign wmask = {{8{s_axi_control_wstrb[3]}}, {8{s_axi_control_wstrb[2]}},
                   {8{s_axi_control_wstrb[1]}}, {8{s_axi_control_wstrb[0]}}};
   assign unused_addr_bits = ^{s_axi_control_awaddr[C_S_AXI_ADDR_WIDTH-1:6],
                               s_axi_control_araddr[C_S_AXI_ADDR_WIDTH-1:6]};

   // Write channel: AW first, then W, then B; one outstanding write.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         wstate_q  <= WRRESET;
         waddr_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         case (wstate_q)
            WRRESET: begin
               wstate_q  <= WRIDLE;
               awready_q <= 1'b1;
            end
            WRIDLE: if (s_axi_control_awvalid) begin
               wstate_q  <= WRDATA;
               waddr_q   <= s_axi_control_awaddr[5:0];
               awready_q <= 1'b0;
               wready_q  <= 1'b1;
            end
            WRDATA: if (s_axi_control_wvalid) begin
               wstate_q <= WRRESP;
               wready_q <= 1'b0;
               bvalid_q <= 1'b1;
            end
            WRRESP: if (s_axi_control_bready) begin
               wstate_q  <= WRIDLE;
               bvalid_q  <= 1'b0;
               awready_q <= 1'b1;
            end
            default: wstate_q <= WRRESET;
         endcase
      end
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         rstate_q  <= RDRESET;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (rstate_q)
            RDRESET: begin
               rstate_q  <= RDIDLE;
               arready_q <= 1'b1;
            end
            RDIDLE: if (s_axi_control_arvalid) begin
               rstate_q  <= RDDATA;
               arready_q <= 1'b0;
               rvalid_q  <= 1'b1;
               rdata_q   <= rdata_mux;
            end
            RDDATA: if (s_axi_control_rready) begin
               rstate_q  <= RDIDLE;
               rvalid_q  <= 1'b0;
               arready_q <= 1'b1;
            end
            default: rstate_q <= RDRESET;
         endcase
      end
   end

   always_comb begin
      rdata_mux = '0;
      case (raddr)
         ADDR_CTRL:   rdata_mux = {24'd0, auto_restart_q, 3'd0, ap_ready_r_q, ap_idle_r_q, done_q, ap_start_q};
         ADDR_GIE:    rdata_mux = {31'd0, gie_q};
         ADDR_IER:    rdata_mux = {30'd0, ier_q};
         ADDR_ISR:    rdata_mux = {30'd0, isr_q};
         ADDR_SCALAR: rdata_mux = scalar00_q;
         ADDR_A_LO:   rdata_mux = a_q[31:0];
         ADDR_A_HI:   rdata_mux = a_q[63:32];
         ADDR_B_LO:   rdata_mux = b_q[31:0];
         ADDR_B_HI:   rdata_mux = b_q[63:32];
         default:     rdata_mux = '0;
      endcase
   end

   always_comb begin
      ap_start_d     = ap_start_q;
      auto_restart_d = auto_restart_q;
      done_d         = done_q;
      gie_d          = gie_q;
      ier_d          = ier_q;
      isr_d          = isr_q;
      scalar00_d     = scalar00_q;
      a_d            = a_q;
      b_d            = b_q;
      ap_idle_r_d    = ap_idle;
      ap_ready_r_d   = ap_ready;
      interrupt_d    = gie_q & (isr_q[0] | isr_q[1]);

      // Kernel-side clear comes first so a same-cycle start write overrides it.
      if (ap_ready && !auto_restart_q)
         ap_start_d = 1'b0;

      if (w_hs) begin
         case (waddr_q)
            ADDR_CTRL: if (s_axi_control_wstrb[0]) begin
               if (s_axi_control_wdata[0])
                  ap_start_d = 1'b1;
               auto_restart_d = s_axi_control_wdata[7];
            end
            ADDR_GIE:    if (s_axi_control_wstrb[0]) gie_d = s_axi_control_wdata[0];
            ADDR_IER:    if (s_axi_control_wstrb[0]) ier_d = s_axi_control_wdata[1:0];
            ADDR_ISR:    if (s_axi_control_wstrb[0]) isr_d = isr_q ^ s_axi_control_wdata[1:0];
            ADDR_SCALAR: scalar00_d  = (scalar00_q & ~wmask) | (s_axi_control_wdata & wmask);
            ADDR_A_LO:   a_d[31:0]   = (a_q[31:0] & ~wmask) | (s_axi_control_wdata & wmask);
            ADDR_A_HI:   a_d[63:32]  = (a_q[63:32] & ~wmask) | (s_axi_control_wdata & wmask);
            ADDR_B_LO:   b_d[31:0]   = (b_q[31:0] & ~wmask) | (s_axi_control_wdata & wmask);
            ADDR_B_HI:   b_d[63:32]  = (b_q[63:32] & ~wmask) | (s_axi_control_wdata & wmask);
            default: ;
         endcase
      end

      if (ar_hs && raddr == ADDR_CTRL)
         done_d = 1'b0;
      if (ap_done)
         done_d = 1'b1;

      if (ap_done && ier_q[0])
         isr_d[0] = 1'b1;
      if (ap_ready && ier_q[1])
         isr_d[1] = 1'b1;
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         ap_start_q     <= 1'b0;
         auto_restart_q <= 1'b0;
         done_q         <= 1'b0;
         ap_idle_r_q    <= 1'b0;
         ap_ready_r_q   <= 1'b0;
         gie_q          <= 1'b0;
         ier_q          <= '0;
         isr_q          <= '0;
         interrupt_q    <= 1'b0;
         scalar00_q     <= '0;
         a_q            <= '0;
         b_q            <= '0;
      end else begin
         ap_start_q     <= ap_start_d;
         auto_restart_q <= auto_restart_d;
         done_q         <= done_d;
         ap_idle_r_q    <= ap_idle_r_d;
         ap_ready_r_q   <= ap_ready_r_d;
         gie_q          <= gie_d;
         ier_q          <= ier_d;
         isr_q          <= isr_d;
         interrupt_q    <= interrupt_d;
         scalar00_q     <= scalar00_d;
         a_q            <= a_d;
         b_q            <= b_d;
      end
   end

   assign s_axi_control_awready = awready_q;
   assign s_axi_control_wready  = wready_q;
   assign s_axi_control_bvalid  = bvalid_q;
   assign s_axi_control_bresp   = 2'b00;
   assign s_axi_control_arready = arready_q;
   assign s_axi_control_rvalid  = rvalid_q;
   assign s_axi_control_rdata   = rdata_q;
   assign s_axi_control_rresp   = 2'b00;
   assign interrupt             = interrupt_q;
   assign ap_start              = ap_start_q;
   assign scalar00              = scalar00_q;
   assign A                     = a_q;
   assign B                     = b_q;

endmodule

// File: tb/tb_vadd_a_b_control_s_axi.sv
// tb/tb_vadd_a_b_control_s_axi.sv - directed bench for vadd_a_b_control_s_axi
// Read data is checked against a queue of expected values pushed when each read is issued.
module tb_vadd_a_b_control_s_axi;

   logic        ap_clk = 1'b0;
   logic        areset = 1'b1;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [11:0] awaddr = '0, araddr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, scalar00;
   logic [63:0] A, B;
   logic        interrupt, ap_start;
   logic        ap_done = 1'b0, ap_idle = 1'b0, ap_ready = 1'b0;

   int          tests = 0;
   int          failed = 0;
   logic [31:0] sb_q[$];

   vadd_a_b_control_s_axi dut (
      .ap_clk(ap_clk), .areset(areset),
      .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready), .s_axi_control_awaddr(awaddr),
      .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready), .s_axi_control_wdata(wdata),
      .s_axi_control_wstrb(wstrb), .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
      .s_axi_control_bresp(bresp), .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
      .s_axi_control_araddr(araddr), .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
      .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp), .interrupt(interrupt),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .scalar00(scalar00), .A(A), .B(B)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold);
      int n;
      awaddr = addr; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 50) begin @(negedge ap_clk); n++; end
      chk("awready_seen", awready, 1);
      @(negedge ap_clk);
      awvalid = 1'b0; wdata = data; wstrb = strb; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge ap_clk); n++; end
      chk("wready_seen", wready, 1);
      @(negedge ap_clk);
      wvalid = 1'b0;
      chk("bvalid_after_w", bvalid, 1);
      chk("bresp", bresp, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge ap_clk);
         chk("bvalid_hold", bvalid, 1);
         chk("awready_hold", awready, 0);
      end
      bready = 1'b1;
      @(negedge ap_clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp, input int hold);
      int n;
      logic [31:0] e;
      sb_q.push_back(exp);
      araddr = addr; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin @(negedge ap_clk); n++; end
      chk("arready_seen", arready, 1);
      @(negedge ap_clk);
      arvalid = 1'b0;
      chk("rvalid_after_ar", rvalid, 1);
      e = sb_q.pop_front();
      chk("rdata", rdata, e);
      chk("rresp", rresp, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge ap_clk);
         chk("rvalid_hold", rvalid, 1);
         chk("rdata_hold", rdata, e);
         chk("arready_hold", arready, 0);
      end
      rready = 1'b1;
      @(negedge ap_clk);
      rready = 1'b0;
   endtask

   task automatic pulse_done();
      ap_done = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge ap_clk);
      chk("reset_handshakes", {awready, wready, bvalid, arready, rvalid}, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_start_irq_scalar", {ap_start, interrupt, scalar00}, 0);
      chk("reset_A", A, 0);
      chk("reset_B", B, 0);
      areset = 1'b0;
      @(negedge ap_clk);
      chk("idle_ready", {awready, arready}, 2'b11);

      // 64-bit A argument assembled from two halves
      axi_write(12'h018, 32'h1000_0000, 4'hF, 0);
      axi_write(12'h01C, 32'h0000_0001, 4'hF, 0);
      chk("A_value", A, 64'h0000_0001_1000_0000);

      // partial byte enables on scalar00, and unmapped offsets
      axi_write(12'h010, 32'hAABB_CCDD, 4'h3, 0);
      chk("scalar00_strb", scalar00, 64'h0000_CCDD);
      axi_read(12'h010, 32'h0000_CCDD, 0);
      axi_read(12'h018, 32'h1000_0000, 0);
      axi_read(12'h01C, 32'h0000_0001, 0);
      axi_write(12'h03C, 32'hFFFF_FFFF, 4'hF, 0);
      axi_read(12'h03C, 32'h0, 0);

      // start, ready clears start, done is clear-on-read
      axi_write(12'h000, 32'h1, 4'hF, 0);
      chk("ap_start_set", ap_start, 1);
      ap_ready = 1'b1;
      @(negedge ap_clk);
      ap_ready = 1'b0;
      chk("ap_start_cleared", ap_start, 0);
      pulse_done();
      axi_read(12'h000, 32'h02, 0);
      axi_read(12'h000, 32'h00, 0);

      // auto_restart keeps start high through ready pulses
      axi_write(12'h000, 32'h81, 4'hF, 0);
      for (int k = 0; k < 2; k++) begin
         ap_ready = 1'b1;
         @(negedge ap_clk);
         ap_ready = 1'b0;
         chk("auto_restart_start", ap_start, 1);
         @(negedge ap_clk);
         chk("auto_restart_start2", ap_start, 1);
      end
      ap_idle = 1'b1;
      @(negedge ap_clk);
      axi_read(12'h000, 32'h85, 0);
      ap_idle = 1'b0;
      axi_write(12'h000, 32'h00, 4'hF, 0);
      chk("write0_keeps_start", ap_start, 1);
      ap_ready = 1'b1;
      @(negedge ap_clk);
      ap_ready = 1'b0;
      chk("start_clear_no_auto", ap_start, 0);

      // interrupt path
      axi_write(12'h004, 32'h1, 4'hF, 0);
      axi_write(12'h008, 32'h1, 4'hF, 0);
      pulse_done();
      chk("irq_latency", interrupt, 0);
      @(negedge ap_clk);
      chk("irq_set", interrupt, 1);
      axi_read(12'h00C, 32'h1, 0);
      axi_write(12'h00C, 32'h1, 4'hF, 0);
      chk("irq_cleared", interrupt, 0);
      axi_read(12'h00C, 32'h0, 0);

      // backpressure on B and R
      axi_write(12'h024, 32'h2222_0000, 4'hF, 5);
      axi_write(12'h028, 32'h1234_5678, 4'h8, 0);
      chk("B_value", B, 64'h1200_0000_2222_0000);
      axi_read(12'h024, 32'h2222_0000, 5);

      // reset in the middle of a write and a read
      axi_write(12'h000, 32'h1, 4'hF, 0);
      pulse_done();
      @(negedge ap_clk);
      chk("pre_reset_irq", {interrupt, ap_start}, 2'b11);
      awaddr = 12'h010; awvalid = 1'b1;
      araddr = 12'h010; arvalid = 1'b1;
      @(negedge ap_clk);
      awvalid = 1'b0; arvalid = 1'b0;
      chk("mid_txn", {wready, rvalid}, 2'b11);
      areset = 1'b1;
      @(negedge ap_clk);
      chk("abort_handshakes", {awready, wready, bvalid, arready, rvalid}, 0);
      chk("abort_rdata", rdata, 0);
      chk("abort_start_irq_scalar", {ap_start, interrupt, scalar00}, 0);
      chk("abort_A", A, 0);
      chk("abort_B", B, 0);
      areset = 1'b0;
      @(negedge ap_clk);
      chk("post_reset_ready", {awready, bvalid, arready, rvalid}, 4'b1010);
      axi_read(12'h00C, 32'h0, 0);
      axi_read(12'h028, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/vadd_a_b_control_s_axi.md
Name: vadd_a_b_control_s_axi

Overview:
- AXI4-Lite slave register file directly upstream of the Vadd A/B kernel top; the host writes it over s_axi_control.
- Drives the kernel's ap_start, scalar00, A and B inputs.
- Collects ap_done, ap_idle and ap_ready back from the kernel into readable status bits and a level interrupt.
- Implements the ap_ctrl_hs register map expected by the Vitis runtime.

Parameters:
- C_S_AXI_ADDR_WIDTH, 12, AXI-Lite address width; only bits [5:0] are decoded.
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; fixed at 32, other values unsupported.

Ports:
- ap_clk  in  1  kernel clock; all logic on posedge.
- areset  in  1  synchronous active-high reset.
- s_axi_control_awvalid / s_axi_control_awready  in/out  1/1  write-address handshake.
- s_axi_control_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s_axi_control_wvalid / s_axi_control_wready  in/out  1/1  write-data handshake.
- s_axi_control_wdata  in  32  write data.
- s_axi_control_wstrb  in  4  byte enables.
- s_axi_control_bvalid / s_axi_control_bready  out/in  1/1  write-response handshake.
- s_axi_control_bresp  out  2  write response; constant 2'b00.
- s_axi_control_arvalid / s_axi_control_arready  in/out  1/1  read-address handshake.
- s_axi_control_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s_axi_control_rvalid / s_axi_control_rready  out/in  1/1  read-data handshake.
- s_axi_control_rdata  out  32  read data.
- s_axi_control_rresp  out  2  read response; constant 2'b00.
- interrupt  out  1  level interrupt to the host.
- ap_start  out  1  start level to the kernel.
- ap_done, ap_idle, ap_ready  in  1 each  status pulses/levels from the kernel.
- scalar00  out  32  scalar argument.
- A, B  out  64 each  buffer base addresses.

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL: bit0 ap_start (RW, self-clearing); bit1 ap_done (RO, clear-on-read); bit2 ap_idle (RO); bit3 ap_ready (RO); bit7 auto_restart (RW).
  - 0x04 GIE: bit0. 0x08 IER: bits[1:0]. 0x0C ISR: bits[1:0], toggle-on-write.
  - 0x10 scalar00. 0x18 A[31:0], 0x1C A[63:32]. 0x24 B[31:0], 0x28 B[63:32].
  - Any other offset: writes ignored, reads return 0. Response is always OKAY.
- Reset:
  - Outputs: awready, wready, bvalid, arready, rvalid = 0; rdata = 0; ap_start = 0; interrupt = 0; scalar00/A/B = 0.
  - Registers: GIE, IER, ISR, auto_restart, done bit all 0.
  - Reset mid-transaction aborts it; no response is issued.
- Write FSM: WRRESET -> WRIDLE -> WRDATA -> WRRESP -> WRIDLE.
  - WRRESET is held while areset=1 and exits on the first cycle with areset=0.
  - awready=1 only in WRIDLE. The AW handshake latches awaddr and moves to WRDATA.
  - wready=1 only in WRDATA. The W handshake commits the write in that same cycle and moves to WRRESP.
  - bvalid=1 only in WRRESP; it is held until bready, then returns to WRIDLE.
  - W is never accepted before AW. There is one outstanding write at a time.
- Read FSM: RDRESET -> RDIDLE -> RDDATA -> RDIDLE.
  - arready=1 only in RDIDLE. The AR handshake in cycle N registers rdata, and rvalid=1 from cycle N+1.
  - rvalid and rdata are held stable until rready.
- wstrb: applied per byte on scalar00, A and B halves, GIE, IER and CTRL. For ISR, a bit toggles only if wstrb[0]=1 and the wdata bit is 1.
- ap_start:
  - Set when CTRL is written with wstrb[0]=1 and wdata[0]=1.
  - Cleared the cycle after ap_ready=1 when auto_restart=0.
  - If auto_restart=1 it stays set.
  - A CTRL write setting start in the same cycle as ap_ready wins (stays 1).
  - Writing 0 to bit0 does not clear it.
- Done bit:
  - Set on ap_done=1.
  - Cleared on an AR handshake to 0x00. The read returns the pre-clear value.
  - An ap_done in the same cycle as that handshake leaves the bit set.
- ap_idle and ap_ready bits: ap_idle_r and ap_ready_r are registered copies of the kernel inputs, 1-cycle latency. CTRL reads return them.
- ISR:
  - bit0 is set on ap_done & IER[0]; bit1 is set on ap_ready & IER[1].
  - A toggle-write and a set event in the same cycle: the set wins.
- interrupt: registered, GIE & (ISR[0] | ISR[1]), 1 cycle after the ISR change.
- Argument outputs are driven directly from the registers, with 0 extra cycles after the write commit.

Test Plan:
- Reset then write 0x18=0x1000_0000 and 0x1C=0x0000_0001, wstrb=0xF -> A=0x0000_0001_1000_0000 the cycle after the W handshake; bvalid next cycle, bresp=0.
- Write 0x10=0xAABBCCDD with wstrb=0x3 onto reset value 0 -> scalar00=0x0000CCDD; read 0x10 returns 0x0000CCDD with rvalid 1 cycle after the AR handshake.
- Write 0x00=0x1 -> ap_start=1. Pulse ap_ready -> ap_start=0 next cycle. Pulse ap_done -> read 0x00 bit1=1, a second read gives bit1=0.
- Write 0x00=0x81 (auto_restart) then pulse ap_ready twice -> ap_start stays 1 throughout.
- Write GIE=1, IER=1, pulse ap_done -> ISR=0x1 and interrupt=1. Write ISR=0x1 -> ISR=0, interrupt=0 one cycle later.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and rdata stay stable; awready/arready stay 0. Assert areset mid-transaction -> all outputs 0 the next cycle.
